// File: rtl/rtc_pkg.sv
// rtc_pkg: shared field codes, widths, limits, reset values and calendar
// helpers for the rtc_core real-time-clock/calendar.
package rtc_pkg;

  // Field codes used on set_field
  localparam logic [2:0] FIELD_SUBSEC = 3'd0;
  localparam logic [2:0] FIELD_SEC    = 3'd1;
  localparam logic [2:0] FIELD_MIN    = 3'd2;
  localparam logic [2:0] FIELD_HOUR   = 3'd3;
  localparam logic [2:0] FIELD_DAY    = 3'd4;
  localparam logic [2:0] FIELD_MONTH  = 3'd5;
  localparam logic [2:0] FIELD_YEAR_L = 3'd6;
  localparam logic [2:0] FIELD_YEAR_H = 3'd7;

  // Field widths
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 7;

  // Field limits
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [DAY_W-1:0]  DAY_MIN  = 5'd1;
  localparam logic [MON_W-1:0]  MON_MIN  = 4'd1;
  localparam logic [MON_W-1:0]  MON_MAX  = 4'd12;
  localparam logic [YEAR_W-1:0] YEAR_MAX = 7'd99;

  // Reset values (calendar starts at 1 Jan 2000, 00:00:00)
  localparam logic [SEC_W-1:0]  RST_SEC    = 6'd0;
  localparam logic [MIN_W-1:0]  RST_MIN    = 6'd0;
  localparam logic [HOUR_W-1:0] RST_HOUR   = 5'd0;
  localparam logic [DAY_W-1:0]  RST_DAY    = 5'd1;
  localparam logic [MON_W-1:0]  RST_MON    = 4'd1;
  localparam logic [YEAR_W-1:0] RST_YEAR_L = 7'd0;
  localparam logic [YEAR_W-1:0] RST_YEAR_H = 7'd20;

  // Gregorian leap rule on a two-part year: centuries only when divisible by 400
  function automatic logic is_leap(input logic [YEAR_W-1:0] year_h,
                                   input logic [YEAR_W-1:0] year_l);
    logic leap;
    if (year_l != 7'd0) begin
      leap = (year_l[1:0] == 2'd0);
    end else begin
      leap = (year_h[1:0] == 2'd0);
    end
    return leap;
  endfunction

  // Length of a month in days
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                     input logic leap);
    logic [DAY_W-1:0] dim;
    case (month)
      4'd2: begin
        if (leap) begin
          dim = 5'd29;
        end else begin
          dim = 5'd28;
        end
      end
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default: dim = 5'd31;
    endcase
    return dim;
  endfunction

  // Saturate a write value into [lo, hi]
  function automatic logic [15:0] clamp_u16(input logic [15:0] v,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    logic [15:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides the input clock down to the sub-second tick.
// Counts 0..DIV-1 and ticks on the terminal count; clear restarts the
// count, hold freezes it and suppresses the tick.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] PRE_TERM = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_at_term;

  // Division counter with a registered "at terminal count" flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_at_term <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_at_term <= 1'b0;
    end else if (i_hold) begin
      r_cnt     <= r_cnt;
      r_at_term <= r_at_term;
    end else if (r_at_term) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_at_term <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_at_term <= (r_cnt == PRE_TERM);
    end
  end

  assign o_tick = r_at_term & ~i_hold;

endmodule

// File: rtl/rtc_core.sv
// rtc_core: real-time clock/calendar with Gregorian leap handling, clamped
// field writes through a valid/ready handshake, and per-channel alarms.
// Build option: define RTC_ALARM_EN to include the alarm comparators and
// flags; without it alarm_pulse/alarm_flag are tied low.
module rtc_core
  import rtc_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_ALARMS = 2,
  parameter int SUB_W      = $clog2(TICK_HZ)
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     set_valid,
  output logic                     set_ready,
  input  logic [2:0]               set_field,
  input  logic [15:0]              set_value,
  output logic [SUB_W-1:0]         subsec,
  output logic [5:0]               second,
  output logic [5:0]               minute,
  output logic [4:0]               hour,
  output logic [4:0]               day,
  output logic [3:0]               month,
  output logic [6:0]               year_l,
  output logic [6:0]               year_h,
  input  logic [NUM_ALARMS-1:0]    alarm_en,
  input  logic [17*NUM_ALARMS-1:0] alarm_time,
  input  logic [NUM_ALARMS-1:0]    alarm_ack,
  output logic [NUM_ALARMS-1:0]    alarm_pulse,
  output logic [NUM_ALARMS-1:0]    alarm_flag
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICK_HZ - 1);

  logic [SUB_W-1:0]  r_subsec;
  logic [SEC_W-1:0]  r_second;
  logic [MIN_W-1:0]  r_minute;
  logic [HOUR_W-1:0] r_hour;
  logic [DAY_W-1:0]  r_day;
  logic [MON_W-1:0]  r_month;
  logic [YEAR_W-1:0] r_year_l, r_year_h;
  logic              r_set_ready;

  logic w_tick, w_accept, w_presc_clr, w_sub_wrap;
  logic [DAY_W-1:0] w_dim_cur, w_dim_wr, w_reclamp_day;
  logic [15:0] w_lo, w_hi, w_wval;
  logic [MON_W-1:0]  w_wr_month;
  logic [YEAR_W-1:0] w_wr_yl, w_wr_yh;

  logic [SUB_W-1:0]  w_tk_subsec, w_nx_subsec;
  logic [SEC_W-1:0]  w_tk_second, w_nx_second;
  logic [MIN_W-1:0]  w_tk_minute, w_nx_minute;
  logic [HOUR_W-1:0] w_tk_hour,   w_nx_hour;
  logic [DAY_W-1:0]  w_tk_day,    w_nx_day;
  logic [MON_W-1:0]  w_tk_month,  w_nx_month;
  logic [YEAR_W-1:0] w_tk_year_l, w_nx_year_l, w_tk_year_h, w_nx_year_h;

  assign w_accept    = set_valid & r_set_ready;
  assign w_presc_clr = w_accept & ((set_field == FIELD_SUBSEC) | (set_field == FIELD_SEC));
  assign w_dim_cur   = days_in_month(r_month, is_leap(r_year_h, r_year_l));

  rtc_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk   (CLOCK_50),
    .i_rst   (rst),
    .i_clear (w_presc_clr),
    .i_hold  (hold),
    .o_tick  (w_tick)
  );

  // Full single-edge carry ripple from subsec up to year_h
  always_comb begin
    w_tk_subsec = r_subsec;
    w_tk_second = r_second;
    w_tk_minute = r_minute;
    w_tk_hour   = r_hour;
    w_tk_day    = r_day;
    w_tk_month  = r_month;
    w_tk_year_l = r_year_l;
    w_tk_year_h = r_year_h;
    w_sub_wrap  = 1'b0;
    if (r_subsec != SUB_MAX) begin
      w_tk_subsec = r_subsec + SUB_W'(1);
    end else begin
      w_sub_wrap  = 1'b1;
      w_tk_subsec = {SUB_W{1'b0}};
      if (r_second != SEC_MAX) begin
        w_tk_second = r_second + 6'd1;
      end else begin
        w_tk_second = 6'd0;
        if (r_minute != MIN_MAX) begin
          w_tk_minute = r_minute + 6'd1;
        end else begin
          w_tk_minute = 6'd0;
          if (r_hour != HOUR_MAX) begin
            w_tk_hour = r_hour + 5'd1;
          end else begin
            w_tk_hour = 5'd0;
            if (r_day < w_dim_cur) begin
              w_tk_day = r_day + 5'd1;
            end else begin
              w_tk_day = DAY_MIN;
              if (r_month != MON_MAX) begin
                w_tk_month = r_month + 4'd1;
              end else begin
                w_tk_month = MON_MIN;
                if (r_year_l != YEAR_MAX) begin
                  w_tk_year_l = r_year_l + 7'd1;
                end else begin
                  w_tk_year_l = 7'd0;
                  if (r_year_h != YEAR_MAX) begin
                    w_tk_year_h = r_year_h + 7'd1;
                  end else begin
                    w_tk_year_h = 7'd0;
                  end
                end
              end
            end
          end
        end
      end
    end
  end

  // Legal range of the addressed field and the clamped write value
  always_comb begin
    w_lo = 16'd0;
    w_hi = 16'd0;
    case (set_field)
      FIELD_SUBSEC: w_hi = 16'(SUB_MAX);
      FIELD_SEC:    w_hi = 16'(SEC_MAX);
      FIELD_MIN:    w_hi = 16'(MIN_MAX);
      FIELD_HOUR:   w_hi = 16'(HOUR_MAX);
      FIELD_DAY: begin
        w_lo = 16'(DAY_MIN);
        w_hi = 16'(w_dim_cur);
      end
      FIELD_MONTH: begin
        w_lo = 16'(MON_MIN);
        w_hi = 16'(MON_MAX);
      end
      FIELD_YEAR_L: w_hi = 16'(YEAR_MAX);
      FIELD_YEAR_H: w_hi = 16'(YEAR_MAX);
      default: begin
        w_lo = 16'd0;
        w_hi = 16'd0;
      end
    endcase
    w_wval = clamp_u16(set_value, w_lo, w_hi);
  end

  // Day re-clamped against the month/year that a write is about to install
  always_comb begin
    w_wr_month = r_month;
    w_wr_yl    = r_year_l;
    w_wr_yh    = r_year_h;
    if (set_field == FIELD_MONTH) begin
      w_wr_month = w_wval[MON_W-1:0];
    end else if (set_field == FIELD_YEAR_L) begin
      w_wr_yl = w_wval[YEAR_W-1:0];
    end else if (set_field == FIELD_YEAR_H) begin
      w_wr_yh = w_wval[YEAR_W-1:0];
    end else begin
      w_wr_month = r_month;
    end
    w_dim_wr = days_in_month(w_wr_month, is_leap(w_wr_yh, w_wr_yl));
    if (r_day > w_dim_wr) begin
      w_reclamp_day = w_dim_wr;
    end else begin
      w_reclamp_day = r_day;
    end
  end

  // Next state: an accepted write wins and discards a coincident tick
  always_comb begin
    w_nx_subsec = r_subsec;
    w_nx_second = r_second;
    w_nx_minute = r_minute;
    w_nx_hour   = r_hour;
    w_nx_day    = r_day;
    w_nx_month  = r_month;
    w_nx_year_l = r_year_l;
    w_nx_year_h = r_year_h;
    if (w_accept) begin
      case (set_field)
        FIELD_SUBSEC: w_nx_subsec = w_wval[SUB_W-1:0];
        FIELD_SEC:    w_nx_second = w_wval[SEC_W-1:0];
        FIELD_MIN:    w_nx_minute = w_wval[MIN_W-1:0];
        FIELD_HOUR:   w_nx_hour   = w_wval[HOUR_W-1:0];
        FIELD_DAY:    w_nx_day    = w_wval[DAY_W-1:0];
        FIELD_MONTH: begin
          w_nx_month = w_wval[MON_W-1:0];
          w_nx_day   = w_reclamp_day;
        end
        FIELD_YEAR_L: begin
          w_nx_year_l = w_wval[YEAR_W-1:0];
          w_nx_day    = w_reclamp_day;
        end
        FIELD_YEAR_H: begin
          w_nx_year_h = w_wval[YEAR_W-1:0];
          w_nx_day    = w_reclamp_day;
        end
        default: w_nx_subsec = r_subsec;
      endcase
    end else if (w_tick) begin
      w_nx_subsec = w_tk_subsec;
      w_nx_second = w_tk_second;
      w_nx_minute = w_tk_minute;
      w_nx_hour   = w_tk_hour;
      w_nx_day    = w_tk_day;
      w_nx_month  = w_tk_month;
      w_nx_year_l = w_tk_year_l;
      w_nx_year_h = w_tk_year_h;
    end else begin
      w_nx_subsec = r_subsec;
    end
  end

  // Time/calendar registers and write-handshake ready
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_subsec    <= {SUB_W{1'b0}};
      r_second    <= RST_SEC;
      r_minute    <= RST_MIN;
      r_hour      <= RST_HOUR;
      r_day       <= RST_DAY;
      r_month     <= RST_MON;
      r_year_l    <= RST_YEAR_L;
      r_year_h    <= RST_YEAR_H;
      r_set_ready <= 1'b1;
    end else begin
      r_subsec    <= w_nx_subsec;
      r_second    <= w_nx_second;
      r_minute    <= w_nx_minute;
      r_hour      <= w_nx_hour;
      r_day       <= w_nx_day;
      r_month     <= w_nx_month;
      r_year_l    <= w_nx_year_l;
      r_year_h    <= w_nx_year_h;
      r_set_ready <= ~w_accept;
    end
  end

  assign set_ready = r_set_ready;
  assign subsec    = r_subsec;
  assign second    = r_second;
  assign minute    = r_minute;
  assign hour      = r_hour;
  assign day       = r_day;
  assign month     = r_month;
  assign year_l    = r_year_l;
  assign year_h    = r_year_h;

  logic w_unused_wval;
  assign w_unused_wval = ^w_wval;

`ifdef RTC_ALARM_EN
  logic [NUM_ALARMS-1:0] w_alarm_hit, r_alarm_pulse, r_alarm_flag;

  // Alarm match only on a tick that rolls subsec to zero (never on writes)
  always_comb begin
    w_alarm_hit = {NUM_ALARMS{1'b0}};
    for (int k = 0; k < NUM_ALARMS; k++) begin
      w_alarm_hit[k] = w_tick & ~w_accept & w_sub_wrap & alarm_en[k] &
                       ({w_tk_hour, w_tk_minute, w_tk_second} == alarm_time[17*k +: 17]);
    end
  end

  // One-cycle strobe plus sticky flag; a new match beats a same-cycle ack
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_alarm_pulse <= {NUM_ALARMS{1'b0}};
      r_alarm_flag  <= {NUM_ALARMS{1'b0}};
    end else begin
      r_alarm_pulse <= w_alarm_hit;
      r_alarm_flag  <= (r_alarm_flag & ~alarm_ack) | w_alarm_hit;
    end
  end

  assign alarm_pulse = r_alarm_pulse;
  assign alarm_flag  = r_alarm_flag;
`else
  assign alarm_pulse = {NUM_ALARMS{1'b0}};
  assign alarm_flag  = {NUM_ALARMS{1'b0}};

  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_en, alarm_time, alarm_ack, w_sub_wrap};
`endif

endmodule
